// File: rtl/types_pkg.sv
// Shared pipeline types: instruction word, memory-control bundle and the
// memory-stage handshake state encoding.
package types_pkg;

    typedef logic [15:0] uword;

    typedef struct packed {
        logic mem2r;   // load: writeback takes memory read data
        logic memwr;   // store
    } memc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } memstage_state_t;

    // An instruction touches data memory if it either loads or stores.
    function automatic logic is_mem_op(input memc_t m);
        return m.mem2r || m.memwr;
    endfunction

endpackage

// File: rtl/mem_stage_pipe_if.sv
// Data-memory bus: req/gnt request phase plus rvalid read-return phase.
// master = memory stage, slave = data memory.
interface mem_stage_pipe_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_req_fsm.sv
// Memory-access handshake controller for mem_stage_pipe: owns the
// IDLE/REQ/WAIT/DONE state, the registered req/we bus outputs and, when
// MEM_STAGE_TIMEOUT_EN is defined, the gnt/rvalid timeout counter and the
// sticky mem_err flag.
module mem_req_fsm
    import types_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_sys,
    input  logic              start,      // accepted memory op this cycle
    input  logic              write,      // accepted op is a store
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output memstage_state_t   state,
    output logic              mem_req,
    output logic              mem_we,
    output logic              load,       // result registers load this edge
    output logic [DATA_W-1:0] load_data,  // read data to load with it
    output logic              mem_err
);

    logic timeout_hit;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             err_q;

    // Expiry only counts while the awaited response is still missing.
    assign timeout_hit = ((state == REQ && !mem_gnt) || (state == WAIT && !mem_rvalid))
                         && (cnt == CNT_W'(TIMEOUT - 1));

    // Cycle counter: cleared on entry to REQ (from IDLE) and to WAIT (on gnt).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == IDLE || (state == REQ && mem_gnt)) begin
            cnt <= '0;
        end else if (state == REQ || state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign mem_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    // Result-load strobe: every transition into DONE captures the result.
    // NOTE: default assignment first so no path leaves load unassigned (no latch).
    always_comb begin
        load = 1'b0;
        case (state)
            REQ:     load = timeout_hit || (mem_gnt && (mem_we || mem_rvalid));
            WAIT:    load = timeout_hit || mem_rvalid;
            default: load = 1'b0;
        endcase
    end

    // A timed-out read returns zero instead of whatever is on the bus.
    assign load_data = timeout_hit ? '0 : mem_rdata;

    // Handshake state machine with registered req/we outputs.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                        mem_we  <= write;
                    end
                end
                REQ: begin
                    if (timeout_hit) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        // Stores never see rvalid; a read may return in the gnt cycle.
                        state   <= (mem_we || mem_rvalid) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (timeout_hit || mem_rvalid) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Halt parks the finished result here until it can be delivered.
                    if (!halt_sys) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_pipe.sv
// Pipeline memory-access stage between execute and writeback. Captures the
// execute-stage bundle, runs at most one data-memory access at a time over
// the req/gnt/rvalid bus and presents the writeback bundle with a one-cycle
// out_valid pulse. Optional timeout: define MEM_STAGE_TIMEOUT_EN.
module mem_stage_pipe
    import types_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int HI_W    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt_sys,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  uword                   instruction,
    input  logic [HI_W+DATA_W-1:0] alu,
    input  memc_t                  memc,
    input  logic [DATA_W-1:0]      r1_data,
    input  logic                   r0_en,
    output logic                   out_valid,
    output logic [HI_W+DATA_W-1:0] data,
    output logic [DATA_W-1:0]      r1_data_out,
    output memc_t                  out_memc,
    output logic                   out_r0_en,
    output uword                   instruction_out,
    mem_stage_pipe_if.master       bus,
    output logic                   mem_err
);

    memstage_state_t        state;
    logic                   accept;
    logic                   is_mem;
    logic                   fsm_req;
    logic                   fsm_we;
    logic                   fsm_load;
    logic [DATA_W-1:0]      fsm_data;
    logic                   nonmem_pulse;

    uword                   req_instr;
    logic [HI_W+DATA_W-1:0] req_alu;
    memc_t                  req_memc;
    logic [DATA_W-1:0]      req_r1;
    logic                   req_r0_en;

    assign is_mem   = is_mem_op(memc);
    assign in_ready = rst && (state == IDLE) && !halt_sys;
    assign accept   = in_valid && in_ready;

    mem_req_fsm #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .halt_sys   (halt_sys),
        .start      (accept && is_mem),
        .write      (memc.memwr),
        .mem_gnt    (bus.mem_gnt),
        .mem_rvalid (bus.mem_rvalid),
        .mem_rdata  (bus.mem_rdata),
        .state      (state),
        .mem_req    (fsm_req),
        .mem_we     (fsm_we),
        .load       (fsm_load),
        .load_data  (fsm_data),
        .mem_err    (mem_err)
    );

    // Address and store data come straight from the request registers, so
    // they stay stable for the whole request phase.
    assign bus.mem_req   = fsm_req;
    assign bus.mem_we    = fsm_we;
    assign bus.mem_addr  = req_alu[ADDR_W-1:0];
    assign bus.mem_wdata = req_r1;

    // Request registers: snapshot of the execute bundle on every accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_instr <= '0;
            req_alu   <= '0;
            req_memc  <= '0;
            req_r1    <= '0;
            req_r0_en <= 1'b0;
        end else if (accept) begin
            req_instr <= instruction;
            req_alu   <= alu;
            req_memc  <= memc;
            req_r1    <= r1_data;
            req_r0_en <= r0_en;
        end
    end

    // Writeback registers: loaded directly on a non-memory accept, or from the
    // request registers when a memory access completes; held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data            <= '0;
            r1_data_out     <= '0;
            out_memc        <= '0;
            out_r0_en       <= 1'b0;
            instruction_out <= '0;
            nonmem_pulse    <= 1'b0;
        end else begin
            nonmem_pulse <= accept && !is_mem;
            if (accept && !is_mem) begin
                data            <= alu;
                r1_data_out     <= r1_data;
                out_memc        <= memc;
                out_r0_en       <= r0_en;
                instruction_out <= instruction;
            end else if (fsm_load) begin
                data            <= {req_alu[HI_W+DATA_W-1:DATA_W],
                                    req_memc.mem2r ? fsm_data : req_alu[DATA_W-1:0]};
                r1_data_out     <= req_r1;
                out_memc        <= req_memc;
                out_r0_en       <= req_r0_en;
                instruction_out <= req_instr;
            end
        end
    end

    // Memory results are delivered during DONE unless the system is halted.
    assign out_valid = nonmem_pulse || (state == DONE && !halt_sys);

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Self-checking bench for mem_stage_pipe: directed vector table, halt and
// reset sequences, randomized transactions against a transaction-level model,
// and the timeout sequence when MEM_STAGE_TIMEOUT_EN is defined.
module tb_mem_stage_pipe;
    import types_pkg::*;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_sys;
    logic        in_valid;
    logic        in_ready;
    uword        instruction;
    logic [31:0] alu;
    memc_t       memc;
    logic [15:0] r1_data;
    logic        r0_en;
    logic        out_valid;
    logic [31:0] data;
    logic [15:0] r1_data_out;
    memc_t       out_memc;
    logic        out_r0_en;
    uword        instruction_out;
    logic        mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_pipe_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_stage_pipe #(
        .DATA_W (16), .ADDR_W (16), .HI_W (16), .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .halt_sys        (halt_sys),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .instruction     (instruction),
        .alu             (alu),
        .memc            (memc),
        .r1_data         (r1_data),
        .r0_en           (r0_en),
        .out_valid       (out_valid),
        .data            (data),
        .r1_data_out     (r1_data_out),
        .out_memc        (out_memc),
        .out_r0_en       (out_r0_en),
        .instruction_out (instruction_out),
        .bus             (bus),
        .mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: what the writeback word should be and how many
    // cycles after the accept edge out_valid appears.
    function automatic logic [31:0] model_data(input logic [31:0] a, input logic m2r,
                                               input logic [15:0] rd);
        return m2r ? {a[31:16], rd} : a;
    endfunction

    function automatic int model_lat(input logic m2r, input logic mwr, input int g, input int r);
        if (!(m2r || mwr)) return 1;    // non-memory: next cycle
        if (mwr) return g + 1;          // store: cycle after gnt
        return g + r + 1;               // load: cycle after rvalid
    endfunction

    task automatic idle_bus();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'($urandom);
    endtask

    // Runs one transaction. gnt_at: REQ cycle (1-based) carrying gnt;
    // rv_at: 0 = rvalid with gnt, else WAIT cycle index of rvalid.
    task automatic run_txn(input logic [31:0] a, input logic m2r, input logic mwr,
                           input logic [15:0] r1, input logic [15:0] ins, input logic r0,
                           input int gnt_at, input int rv_at, input logic [15:0] rd,
                           input logic [31:0] exp_d, input int lat);
        logic is_mem;
        logic is_rd;
        is_mem = m2r || mwr;
        is_rd  = is_mem && !mwr;
        check("in_ready_idle", 128'(in_ready), 128'(1));
        in_valid    = 1'b1;
        alu         = a;
        memc        = '{mem2r: m2r, memwr: mwr};
        r1_data     = r1;
        instruction = ins;
        r0_en       = r0;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        alu         = $urandom;
        r1_data     = 16'($urandom);
        instruction = 16'($urandom);
        r0_en       = 1'($urandom);
        for (int c = 1; c <= lat; c++) begin
            check("out_valid", 128'(out_valid), 128'(c == lat));
            check("in_ready_busy", 128'(in_ready), 128'(!is_mem));
            check("mem_req", 128'(bus.mem_req), 128'(is_mem && c <= gnt_at));
            if (is_mem && c <= gnt_at)
                check("mem_bus", 128'({bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                      128'({mwr, a[15:0], r1}));
            if (c == lat)
                check("result", 128'({data, r1_data_out, instruction_out, out_memc, out_r0_en}),
                      128'({exp_d, r1, ins, m2r, mwr, r0}));
            bus.mem_gnt    = is_mem && (c == gnt_at);
            bus.mem_rvalid = is_rd && (c == gnt_at + rv_at);
            bus.mem_rdata  = bus.mem_rvalid ? rd : 16'($urandom);
            @(posedge clk); #1;
        end
        idle_bus();
        check("out_valid_after", 128'(out_valid), 128'(0));
        check("result_hold", 128'(data), 128'(exp_d));
    endtask

    // Reset asserted mid-transaction (in REQ or WAIT), then late responses.
    task automatic reset_mid(input logic in_wait);
        in_valid = 1'b1;
        alu      = 32'h1111_0030;
        memc     = '{mem2r: 1'b1, memwr: 1'b0};
        @(posedge clk); #1;
        in_valid    = 1'b0;
        bus.mem_gnt = in_wait;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        check("pre_reset_req", 128'(bus.mem_req), 128'(!in_wait));
        rst = 1'b0;
        #1;
        check("reset_async", 128'({bus.mem_req, out_valid, in_ready, data}), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_reset_ready", 128'({in_ready, bus.mem_req, out_valid}), 128'(3'b100));
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'hDEAD;
        @(posedge clk); #1;
        idle_bus();
        check("late_resp_ignored", 128'({out_valid, bus.mem_req, in_ready, data}),
              128'({3'b001, 32'h0}));
    endtask

    typedef struct {
        logic [31:0] a;
        logic        m2r;
        logic        mwr;
        logic [15:0] r1;
        logic [15:0] ins;
        logic        r0;
        int          gnt_at;
        int          rv_at;
        logic [15:0] rd;
        logic [31:0] exp_d;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'h1234_00AB, 1'b0, 1'b0, 16'h0001, 16'h1001, 1'b1, 0, 0, 16'h0000, 32'h1234_00AB, 1};
        vecs[1] = '{32'h0000_0040, 1'b0, 1'b1, 16'hBEEF, 16'h2002, 1'b0, 2, 0, 16'h0000, 32'h0000_0040, 3};
        vecs[2] = '{32'hAAAA_0010, 1'b1, 1'b0, 16'h0003, 16'h3003, 1'b1, 1, 3, 16'h5A5A, 32'hAAAA_5A5A, 5};
        vecs[3] = '{32'hAAAA_0010, 1'b1, 1'b0, 16'h0004, 16'h4004, 1'b0, 1, 0, 16'h1357, 32'hAAAA_1357, 2};
        vecs[4] = '{32'h0F0F_FFFE, 1'b1, 1'b0, 16'h0005, 16'h5005, 1'b1, 3, 1, 16'hFFFF, 32'h0F0F_FFFF, 5};
        vecs[5] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 0, 0, 16'h0000, 32'hFFFF_FFFF, 1};
        vecs[6] = '{32'h8000_FFFF, 1'b0, 1'b1, 16'h0000, 16'h7007, 1'b0, 1, 0, 16'h0000, 32'h8000_FFFF, 2};

        rst         = 1'b0;
        halt_sys    = 1'b0;
        in_valid    = 1'b0;
        instruction = '0;
        alu         = '0;
        memc        = '0;
        r1_data     = '0;
        r0_en       = 1'b0;
        idle_bus();
        #2;
        check("reset_outputs", 128'({out_valid, in_ready, bus.mem_req, mem_err, data,
                                     r1_data_out, instruction_out, out_memc, out_r0_en}), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 128'(in_ready), 128'(1));

        foreach (vecs[i])
            run_txn(vecs[i].a, vecs[i].m2r, vecs[i].mwr, vecs[i].r1, vecs[i].ins, vecs[i].r0,
                    vecs[i].gnt_at, vecs[i].rv_at, vecs[i].rd, vecs[i].exp_d, vecs[i].lat);

        // Halt during WAIT: read, gnt in cycle 1, rvalid in cycle 4, halt cycles 2..6.
        in_valid = 1'b1;
        alu      = 32'hC0DE_0020;
        memc     = '{mem2r: 1'b1, memwr: 1'b0};
        @(posedge clk); #1;
        in_valid = 1'b0;
        memc     = '0;
        for (int c = 1; c <= 8; c++) begin
            halt_sys       = (c >= 2 && c <= 6);
            in_valid       = (c >= 2 && c <= 6);
            bus.mem_gnt    = (c == 1);
            bus.mem_rvalid = (c == 4);
            bus.mem_rdata  = (c == 4) ? 16'hBBBB : 16'($urandom);
            #1;
            check("halt_out_valid", 128'(out_valid), 128'(c == 7));
            check("halt_in_ready", 128'(in_ready), 128'(c == 8));
            if (c == 7) check("halt_result", 128'(data), 128'(32'hC0DE_BBBB));
            @(posedge clk); #1;
        end
        idle_bus();
        check("halt_no_accept", 128'({out_valid, bus.mem_req, in_ready}), 128'(3'b001));

        // Halt in IDLE blocks acceptance of a presented instruction.
        halt_sys = 1'b1;
        in_valid = 1'b1;
        alu      = 32'h9999_9999;
        #1;
        check("halt_idle_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        check("halt_idle_hold", 128'({out_valid, data}), 128'({1'b0, 32'hC0DE_BBBB}));
        halt_sys = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Randomized transactions checked against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            int          kind;
            int          g;
            int          r;
            logic        m2r;
            logic        mwr;
            logic [31:0] a;
            logic [15:0] rd;
            kind = $urandom_range(0, 2);
            m2r  = (kind == 2);
            mwr  = (kind == 1);
            g    = (kind == 0) ? 0 : $urandom_range(1, 4);
            r    = (kind == 2) ? $urandom_range(0, 3) : 0;
            a    = $urandom;
            rd   = 16'($urandom);
            run_txn(a, m2r, mwr, 16'($urandom), 16'($urandom), 1'($urandom), g, r, rd,
                    model_data(a, m2r, rd), model_lat(m2r, mwr, g, r));
        end

`ifdef MEM_STAGE_TIMEOUT_EN
        // No gnt ever: REQ for TB_TIMEOUT cycles, then forced DONE with zero read data.
        in_valid = 1'b1;
        alu      = 32'h7777_0050;
        memc     = '{mem2r: 1'b1, memwr: 1'b0};
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= TB_TIMEOUT + 1; c++) begin
            check("to_mem_req", 128'(bus.mem_req), 128'(c <= TB_TIMEOUT));
            check("to_out_valid", 128'(out_valid), 128'(c == TB_TIMEOUT + 1));
            check("to_mem_err", 128'(mem_err), 128'(c == TB_TIMEOUT + 1));
            if (c == TB_TIMEOUT + 1) check("to_data", 128'(data), 128'(32'h7777_0000));
            @(posedge clk); #1;
        end
        run_txn(32'h0101_0202, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 0, 0, 16'h0, 32'h0101_0202, 1);
        check("to_err_sticky", 128'(mem_err), 128'(1));
        rst = 1'b0;
        #1;
        check("to_err_reset", 128'(mem_err), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
`endif

        reset_mid(1'b0);
        reset_mid(1'b1);
        check("mem_err_final", 128'(mem_err), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
